// File: rtl/iro_sequencer.sv
// Run sequencer for an inverted ring oscillator: serial seed load, gated edge counting,
// and phase capture, all on bclk with the ring's async outputs brought in through synchronisers.
module iro_sequencer #(
    parameter int N_STAGES    = 25,
    parameter int N_PHASES    = 16,
    parameter int SEL_W       = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                bclk,
    input  logic                rst_n,
    input  logic                bvalid,
    input  logic                bdat,
    input  logic                start,
    input  logic                abort,
    input  logic [SEL_W-1:0]    n_stages,
    input  logic [GATE_W-1:0]   gate_len,
    input  logic [N_PHASES-1:0] ro_phases,
    input  logic                ro_tap,
    output logic                ro_enable,
    output logic                ro_hold,
    output logic [N_STAGES-1:0] ro_seed,
    output logic [SEL_W-1:0]    ro_n_stages,
    output logic                seed_full,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    edge_count,
    output logic [N_PHASES-1:0] phase_snap
);

    localparam int LC_W = $clog2(N_STAGES + 1);
    localparam logic [LC_W-1:0]   LOAD_FULL = LC_W'(N_STAGES);
    localparam logic [GATE_W-1:0] HOLD_LAST = GATE_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [N_STAGES-1:0]  seed_q, seed_d;
    logic [LC_W-1:0]      load_cnt_q, load_cnt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic [GATE_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tap_s1_q, tap_s1_d;
    logic                 tap_s2_q, tap_s2_d;
    logic                 tap_s3_q, tap_s3_d;
    logic [N_PHASES-1:0]  ph_s1_q, ph_s1_d;
    logic [N_PHASES-1:0]  ph_s2_q, ph_s2_d;
    logic [CNT_W-1:0]     edge_count_q, edge_count_d;
    logic [N_PHASES-1:0]  phase_snap_q, phase_snap_d;

    logic start_ok;
    logic tap_rise;

    assign start_ok = (state_q == ST_IDLE) && start && !abort;
    assign tap_rise = tap_s2_q & ~tap_s3_q;

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        load_cnt_d   = load_cnt_q;
        sel_d        = sel_q;
        gate_d       = gate_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        edge_count_d = edge_count_q;
        phase_snap_d = phase_snap_q;

        tap_s1_d = ro_tap;
        tap_s2_d = tap_s1_q;
        tap_s3_d = tap_s2_q;
        ph_s1_d  = ro_phases;
        ph_s2_d  = ph_s1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bvalid) begin
                    seed_d = {seed_q[N_STAGES-2:0], bdat};
                    if (load_cnt_q != LOAD_FULL) begin
                        load_cnt_d = load_cnt_q + LC_W'(1);
                    end
                end
                if (start_ok) begin
                    state_d    = ST_ARM;
                    load_cnt_d = '0;
                    sel_d      = n_stages;
                    // A zero gate still gives a one-cycle window.
                    gate_d     = (gate_len == '0) ? GATE_W'(1) : gate_len;
                    cnt_d      = '0;
                    timer_d    = '0;
                end
            end
            ST_ARM: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
            ST_RUN: begin
                if (tap_rise && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (timer_q == gate_q - GATE_W'(1)) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + GATE_W'(1);
                end
            end
            ST_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    state_d      = ST_DONE;
                    edge_count_d = cnt_q;
                    phase_snap_d = ph_s2_q;
                end else begin
                    timer_d = timer_q + GATE_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over every transition and discards any capture in flight.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            edge_count_d = edge_count_q;
            phase_snap_d = phase_snap_q;
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            seed_q       <= '0;
            load_cnt_q   <= '0;
            sel_q        <= '0;
            gate_q       <= '0;
            timer_q      <= '0;
            cnt_q        <= '0;
            tap_s1_q     <= 1'b0;
            tap_s2_q     <= 1'b0;
            tap_s3_q     <= 1'b0;
            ph_s1_q      <= '0;
            ph_s2_q      <= '0;
            edge_count_q <= '0;
            phase_snap_q <= '0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            load_cnt_q   <= load_cnt_d;
            sel_q        <= sel_d;
            gate_q       <= gate_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            tap_s1_q     <= tap_s1_d;
            tap_s2_q     <= tap_s2_d;
            tap_s3_q     <= tap_s3_d;
            ph_s1_q      <= ph_s1_d;
            ph_s2_q      <= ph_s2_d;
            edge_count_q <= edge_count_d;
            phase_snap_q <= phase_snap_d;
        end
    end

    assign ro_enable   = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign ro_hold     = (state_q == ST_HOLD);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign ro_seed     = seed_q;
    assign ro_n_stages = sel_q;
    assign seed_full   = (load_cnt_q == LOAD_FULL);
    assign edge_count  = edge_count_q;
    assign phase_snap  = phase_snap_q;

endmodule
